// File: rtl/demux_nway_stream_if.sv
// Stream bundle between one producer and NCH consumers of the demux.
//
// Handshake: a word moves across a link on a rising clk edge where its
// valid and ready are both 1. in_ready never looks at in_valid. A
// holder of out_valid=1 keeps out_data steady until out_ready takes it.
interface demux_nway_stream_if #(
   parameter int WIDTH = 16,
   parameter int NCH   = 8,
   parameter int SEL_W = 3
);
   logic [WIDTH-1:0]     in_data;
   logic [SEL_W-1:0]     in_sel;
   logic                 in_bcast;
   logic                 in_valid;
   logic                 in_ready;
   logic [NCH*WIDTH-1:0] out_data;
   logic [NCH-1:0]       out_valid;
   logic [NCH-1:0]       out_ready;

   modport master (
      output in_data, in_sel, in_bcast, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_sel, in_bcast, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/demux_nway_stream.sv
// 1-to-NCH registered stream demultiplexer with a one-entry output
// register per channel, broadcast mode, and tracking of words whose
// select is out of range.
module demux_nway_stream #(
   parameter int WIDTH = 16,
   parameter int NCH   = 8,
   parameter int SEL_W = 3,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   demux_nway_stream_if.slave bus,
   output logic               err_sel,
   output logic [CNT_W-1:0]   drop_cnt
);
   localparam logic [SEL_W:0] NCH_EXT = (SEL_W+1)'(NCH);

   logic [NCH-1:0][WIDTH-1:0] data_q;
   logic [NCH-1:0]            vld_q;
   logic [NCH-1:0]            free;
   logic [NCH-1:0]            sel_hit;
   logic [NCH-1:0]            load;
   logic                      sel_ok;
   logic                      in_ready_w;
   logic                      fire;
   logic                      drop;

   // Decode channel availability and the input handshake. A channel
   // being drained this cycle counts as free, so it can be reloaded in
   // the same edge.
   always_comb begin
      free    = ~vld_q | bus.out_ready;
      sel_hit = '0;
      for (int i = 0; i < NCH; i++) begin
         sel_hit[i] = ({1'b0, bus.in_sel} == (SEL_W+1)'(i));
      end
      sel_ok = ({1'b0, bus.in_sel} < NCH_EXT);
      if (bus.in_bcast) begin
         in_ready_w = &free;
      end else if (sel_ok) begin
         in_ready_w = |(free & sel_hit);
      end else begin
         // Out-of-range words are always swallowed.
         in_ready_w = 1'b1;
      end
      fire = bus.in_valid & in_ready_w;
      if (!fire) begin
         load = '0;
      end else if (bus.in_bcast) begin
         load = '1;
      end else begin
         load = sel_hit;
      end
      drop = fire & ~bus.in_bcast & ~sel_ok;
   end

   // Per-channel output registers: a load wins over a drain.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
         vld_q  <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (load[i]) begin
               data_q[i] <= bus.in_data;
               vld_q[i]  <= 1'b1;
            end else if (vld_q[i] & bus.out_ready[i]) begin
               vld_q[i]  <= 1'b0;
            end
         end
      end
   end

   // Sticky select error and saturating drop counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_sel  <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         err_sel <= 1'b1;
         if (drop_cnt != {CNT_W{1'b1}}) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_data  = data_q;
   assign bus.out_valid = vld_q;
endmodule

// File: doc/demux_nway_stream.md
Name: demux_nway_stream

Overview:
- Parametrised 1-to-NCH registered demultiplexer with valid/ready handshake on the input and on every output channel; next generation of the combinational 16-bit 8-way demux gates.
- Routes one WIDTH-bit word per cycle to the channel chosen by in_sel, or to all channels in broadcast mode.
- Holds each word in a one-entry per-channel output register until that channel's consumer accepts it.
- Sits between a single producer (CPU/bus side) and NCH independent consumers (memory banks, I/O ports).

Parameters:
WIDTH, 16, data word width in bits (>=1)
NCH, 8, number of output channels (>=2, need not be a power of two)
SEL_W, 3, select width; must satisfy 2**SEL_W >= NCH
CNT_W, 8, width of the saturating drop counter

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_data  input  WIDTH  word to route
in_sel  input  SEL_W  destination channel index
in_bcast  input  1  1 = write word to every channel; in_sel ignored
in_valid  input  1  producer has a word
in_ready  output  1  block accepts the word this cycle
out_data  output  NCH*WIDTH  flattened; channel i occupies bits [i*WIDTH +: WIDTH]
out_valid  output  NCH  channel i holds a word
out_ready  input  NCH  consumer i accepts the word this cycle
err_sel  output  1  sticky flag: an out-of-range in_sel was accepted
drop_cnt  output  CNT_W  count of dropped (out-of-range) words, saturating

Behaviour:
- Reset (synchronous, clk edge with reset=1): all out_valid=0, all out_data=0, err_sel=0, drop_cnt=0. Reset has priority over every other event. Words in flight are discarded, and an input handshake in the same cycle is ignored.
- Per-channel state: data_q[i] and vld_q[i]. out_data and out_valid are driven directly from these registers (registered outputs).
- free[i] = !vld_q[i] | out_ready[i]. A full channel being drained this cycle may be reloaded in the same cycle.
- in_ready (combinational):
  - in_bcast=1: AND of free[0..NCH-1].
  - in_bcast=0, in_sel<NCH: free[in_sel].
  - in_bcast=0, in_sel>=NCH: 1. The word is always accepted and dropped.
  - in_ready may depend on in_valid-independent signals only (in_sel, in_bcast, out_ready, vld_q). It must not depend on in_valid.
- fire = in_valid & in_ready.
- load[i] = fire & (in_bcast | (in_sel==i)).
- Channel update:
  - if load[i]: data_q[i]<=in_data, vld_q[i]<=1.
  - else if vld_q[i] & out_ready[i]: vld_q[i]<=0.
  - else hold.
- Latency: an accepted word appears on out_data/out_valid exactly one cycle after fire.
- Throughput: 1 word/cycle when the target consumer holds out_ready=1.
- Stability: while out_valid[i]=1 and out_ready[i]=0, out_data[i] is held unchanged.
- out_ready[i] while out_valid[i]=0 has no effect.
- Out-of-range select: fire with in_bcast=0 and in_sel>=NCH loads no channel. It sets err_sel<=1, which stays 1 until reset, and increments drop_cnt by 1. drop_cnt stops at 2**CNT_W-1 (no wrap).
- Broadcast is all-or-nothing: it waits until every channel is free, then loads all channels in the same edge. Out-of-range in_sel is irrelevant under broadcast (no error, no count).
- Independent channels: draining one channel never blocks another. Backpressure on channel j only stalls input words targeting j, or broadcasts.
- No combinational path from in_data to out_data.

Test Plan:
- Reset then idle: assert reset 2 cycles with in_valid=1 -> out_valid=0, out_data=0, err_sel=0, drop_cnt=0, no channel loaded.
- Unicast streaming: out_ready all 1; send 0x1111 sel=0, 0x2222 sel=3, 0x7777 sel=7 on consecutive cycles -> each appears on its channel one cycle later with out_valid pulsed for 1 cycle; in_ready=1 throughout.
- Backpressure/skid: out_ready[2]=0; send 0xABCD sel=2, then 0x1234 sel=2 -> first word held stable, in_ready=0 for the second. Raise out_ready[2] -> in the same cycle in_ready=1, 0x1234 loads, and channel 2 shows 0x1234 next cycle with no bubble.
- Broadcast: out_valid[5]=1, out_ready[5]=0; send 0xBEEF in_bcast=1 -> in_ready=0 until out_ready[5]=1. Then all 8 channels show 0xBEEF on the following cycle.
- Invalid select: NCH=6, SEL_W=3; send sel=6 and sel=7 -> accepted (in_ready=1), no out_valid change, err_sel=1, drop_cnt=2. With CNT_W=2, 5 bad words -> drop_cnt=3.
- Reset mid-operation: channels 1 and 4 full and stalled; assert reset while in_valid=1 sel=1 -> next cycle all out_valid=0, counters cleared, and the input word is not loaded.
